// File: rtl/seq_counter_bank.sv
// Bank of independent up/down counters with clear > load > count > hold priority per channel.
// Latency: one clock from any control/data input to q, tc and ovf; no combinational input-to-output path.
// Backpressure: none; every channel accepts a new command on every rising clock edge.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-high reset (all q <- RESET_VALUE, tc/ovf <- 0)
//   clr[i]         synchronous clear of channel i (also clears its sticky ovf)
//   load[i], d     parallel load of channel i from d[i*WIDTH +: WIDTH]
//   en[i], dir[i]  count enable and direction (1 = up, 0 = down) by STEP
//   q              registered counter values, same packing as d
//   tc[i]          one-cycle pulse for the cycle after a wrap/saturation event
//   ovf[i]         sticky event flag, cleared only by clr[i] or rst
module seq_counter_bank #(
  parameter int WIDTH       = 8,
  parameter int CHANNELS    = 4,
  parameter int STEP        = 1,
  parameter int SATURATE    = 0,
  parameter int RESET_VALUE = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       clr,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS-1:0]       dir,
  input  logic [CHANNELS*WIDTH-1:0] d,
  output logic [CHANNELS*WIDTH-1:0] q,
  output logic [CHANNELS-1:0]       tc,
  output logic [CHANNELS-1:0]       ovf
);

  localparam logic [WIDTH-1:0] LP_RST  = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH:0]   LP_STEP = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] LP_MAX  = '1;
  localparam logic [WIDTH-1:0] LP_MIN  = '0;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [WIDTH-1:0] r_q;
    logic             r_tc;
    logic             r_ovf;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_cnt;
    logic             w_evt;

    // One extra bit on both paths: carry out of the sum flags an up-wrap,
    // borrow (MSB of the difference) flags a down-wrap.
    assign w_sum  = {1'b0, r_q} + LP_STEP;
    assign w_diff = {1'b0, r_q} - LP_STEP;

    always_comb begin
      w_evt = 1'b0;
      w_cnt = r_q;
      if (dir[gi]) begin
        w_evt = w_sum[WIDTH];
        w_cnt = w_sum[WIDTH-1:0];
      end else begin
        w_evt = w_diff[WIDTH];
        w_cnt = w_diff[WIDTH-1:0];
      end
      // Clamp replaces the wrapped value; an attempted step at the limit
      // still reports the event even though q does not move.
      if (SATURATE != 0 && w_evt) begin
        w_cnt = dir[gi] ? LP_MAX : LP_MIN;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_q   <= LP_RST;
        r_tc  <= 1'b0;
        r_ovf <= 1'b0;
      end else if (clr[gi]) begin
        r_q   <= LP_RST;
        r_tc  <= 1'b0;
        r_ovf <= 1'b0;
      end else if (load[gi]) begin
        // Load beats count: the step is discarded and raises no event.
        r_q   <= d[gi*WIDTH +: WIDTH];
        r_tc  <= 1'b0;
      end else if (en[gi]) begin
        r_q   <= w_cnt;
        r_tc  <= w_evt;
        r_ovf <= r_ovf | w_evt;
      end else begin
        r_tc  <= 1'b0;
      end
    end

    assign q[gi*WIDTH +: WIDTH] = r_q;
    assign tc[gi]               = r_tc;
    assign ovf[gi]              = r_ovf;
  end

endmodule

// File: tb/tb_seq_counter_bank.sv
// Self-checking bench for seq_counter_bank: three instances share one stimulus bus.
//   dut A: RESET_VALUE=0x10, wrap, STEP=1
//   dut B: defaults (wrap, STEP=1, RESET_VALUE=0)
//   dut C: SATURATE=1, STEP=3
module tb_seq_counter_bank;

  logic        clk;
  logic        rst;
  logic [3:0]  clr, load, en, dir;
  logic [31:0] d;
  logic [31:0] q_a, q_b, q_c;
  logic [3:0]  tc_a, tc_b, tc_c;
  logic [3:0]  ovf_a, ovf_b, ovf_c;

  seq_counter_bank #(.WIDTH(8), .CHANNELS(4), .STEP(1), .SATURATE(0), .RESET_VALUE('h10)) u_dut_a (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .en(en), .dir(dir), .d(d),
    .q(q_a), .tc(tc_a), .ovf(ovf_a));

  seq_counter_bank #(.WIDTH(8), .CHANNELS(4), .STEP(1), .SATURATE(0), .RESET_VALUE(0)) u_dut_b (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .en(en), .dir(dir), .d(d),
    .q(q_b), .tc(tc_b), .ovf(ovf_b));

  seq_counter_bank #(.WIDTH(8), .CHANNELS(4), .STEP(3), .SATURATE(1), .RESET_VALUE(0)) u_dut_c (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .en(en), .dir(dir), .d(d),
    .q(q_c), .tc(tc_c), .ovf(ovf_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Per-instance configuration seen by the reference model.
  int p_rv   [3] = '{16, 0, 0};
  int p_step [3] = '{1, 1, 3};
  int p_sat  [3] = '{0, 0, 1};

  int m_q   [3][4];
  bit m_tc  [3][4];
  bit m_ovf [3][4];

  typedef struct packed {
    logic [2:0][31:0] q;
    logic [2:0][3:0]  tc;
    logic [2:0][3:0]  ovf;
  } exp_t;

  exp_t sb_q[$];

  typedef struct {
    logic [3:0]  clr, load, en, dir;
    logic [31:0] d;
    int          dut;
    logic [31:0] q;
    logic [3:0]  tc, ovf;
  } vec_t;

  vec_t tbl[13];

  function automatic logic [31:0] get_q(int k);
    return (k == 0) ? q_a : (k == 1) ? q_b : q_c;
  endfunction
  function automatic logic [3:0] get_tc(int k);
    return (k == 0) ? tc_a : (k == 1) ? tc_b : tc_c;
  endfunction
  function automatic logic [3:0] get_ovf(int k);
    return (k == 0) ? ovf_a : (k == 1) ? ovf_b : ovf_c;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 4; i++) begin
        m_q[k][i]   = p_rv[k];
        m_tc[k][i]  = 1'b0;
        m_ovf[k][i] = 1'b0;
      end
  endtask

  // Integer-arithmetic model of one rising edge using the inputs now on the bus.
  task automatic model_edge();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 4; i++) begin
        if (clr[i]) begin
          m_q[k][i] = p_rv[k]; m_tc[k][i] = 0; m_ovf[k][i] = 0;
        end else if (load[i]) begin
          m_q[k][i] = int'(d[i*8 +: 8]); m_tc[k][i] = 0;
        end else if (en[i]) begin
          int s;
          bit ev;
          s  = dir[i] ? m_q[k][i] + p_step[k] : m_q[k][i] - p_step[k];
          ev = dir[i] ? (s > 255) : (s < 0);
          if (p_sat[k] != 0 && ev) s = dir[i] ? 255 : 0;
          m_q[k][i]   = s & 255;
          m_tc[k][i]  = ev;
          m_ovf[k][i] = m_ovf[k][i] | ev;
        end else begin
          m_tc[k][i] = 0;
        end
      end
  endtask

  function automatic exp_t model_snapshot();
    exp_t e;
    e = '0;
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 4; i++) begin
        e.q[k][i*8 +: 8] = 8'(m_q[k][i]);
        e.tc[k][i]       = m_tc[k][i];
        e.ovf[k][i]      = m_ovf[k][i];
      end
    return e;
  endfunction

  task automatic check_all(input string tag, input exp_t e);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_q%0d", tag, k),   get_q(k),          e.q[k]);
      chk($sformatf("%s_tc%0d", tag, k),  {28'd0, get_tc(k)},  {28'd0, e.tc[k]});
      chk($sformatf("%s_ovf%0d", tag, k), {28'd0, get_ovf(k)}, {28'd0, e.ovf[k]});
    end
  endtask

  // Inputs are already on the bus: predict, clock, then pop and compare.
  task automatic cycle();
    exp_t e;
    model_edge();
    sb_q.push_back(model_snapshot());
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL sb_empty: actual=0 entries required>=1");
    end else begin
      e = sb_q.pop_front();
      check_all("sb", e);
    end
  endtask

  // Reset pulse entirely between edges; outputs must follow without a clock.
  task automatic async_reset();
    #1 rst = 1'b1;
    #1;
    chk("arst_q_a", q_a, 32'h10101010);
    chk("arst_q_b", q_b, 32'h00000000);
    chk("arst_q_c", q_c, 32'h00000000);
    chk("arst_tc",  {20'd0, tc_a, tc_b, tc_c},    32'd0);
    chk("arst_ovf", {20'd0, ovf_a, ovf_b, ovf_c}, 32'd0);
    model_reset();
    #1 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Directed vectors; expected values are hand-derived for one instance.
    //            clr     load    en      dir     d             dut q             tc      ovf
    tbl[0]  = '{4'h0, 4'h1, 4'h0, 4'h0, 32'h000000FE, 1, 32'h000000FE, 4'h0, 4'h0};
    tbl[1]  = '{4'h0, 4'h0, 4'h1, 4'h1, 32'h00000000, 1, 32'h000000FF, 4'h0, 4'h0};
    tbl[2]  = '{4'h0, 4'h0, 4'h1, 4'h1, 32'h00000000, 1, 32'h00000000, 4'h1, 4'h1};
    tbl[3]  = '{4'h0, 4'h0, 4'h1, 4'h1, 32'h00000000, 1, 32'h00000001, 4'h0, 4'h1};
    tbl[4]  = '{4'h0, 4'h2, 4'h0, 4'h0, 32'h00000400, 2, 32'h000004FF, 4'h0, 4'h1};
    tbl[5]  = '{4'h0, 4'h0, 4'h2, 4'h0, 32'h00000000, 2, 32'h000001FF, 4'h0, 4'h1};
    tbl[6]  = '{4'h0, 4'h0, 4'h2, 4'h0, 32'h00000000, 2, 32'h000000FF, 4'h2, 4'h3};
    tbl[7]  = '{4'h0, 4'h0, 4'h2, 4'h0, 32'h00000000, 2, 32'h000000FF, 4'h2, 4'h3};
    tbl[8]  = '{4'h0, 4'h4, 4'h0, 4'h0, 32'h00FF0000, 0, 32'h10FF0101, 4'h0, 4'h1};
    tbl[9]  = '{4'h0, 4'h0, 4'h4, 4'h4, 32'h00000000, 0, 32'h10000101, 4'h4, 4'h5};
    tbl[10] = '{4'h4, 4'h4, 4'h4, 4'h4, 32'h00550000, 0, 32'h10100101, 4'h0, 4'h1};
    tbl[11] = '{4'h0, 4'h4, 4'h4, 4'h4, 32'h00550000, 0, 32'h10550101, 4'h0, 4'h1};
    tbl[12] = '{4'h0, 4'h0, 4'h0, 4'h0, 32'h00000000, 0, 32'h10550101, 4'h0, 4'h1};

    rst = 1'b1; clr = '0; load = '0; en = '0; dir = '0; d = '0;
    #3;
    chk("por_q_a", q_a, 32'h10101010);
    chk("por_tc_ovf_a", {24'd0, tc_a, ovf_a}, 32'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;

    // Scramble every channel, then show reset acting between edges.
    load = 4'hF; d = 32'hA5C3_7E19;
    cycle();
    load = 4'h0; d = '0;
    async_reset();

    // Idle hold after reset.
    for (int n = 0; n < 5; n++) begin
      cycle();
      chk($sformatf("hold_q_a_%0d", n), q_a, 32'h10101010);
    end

    // Table-driven directed sequence: wrap up, saturate down, priority.
    for (int v = 0; v < 13; v++) begin
      clr = tbl[v].clr; load = tbl[v].load; en = tbl[v].en; dir = tbl[v].dir; d = tbl[v].d;
      cycle();
      chk($sformatf("tbl%0d_q", v),   get_q(tbl[v].dut), tbl[v].q);
      chk($sformatf("tbl%0d_tc", v),  {28'd0, get_tc(tbl[v].dut)},  {28'd0, tbl[v].tc});
      chk($sformatf("tbl%0d_ovf", v), {28'd0, get_ovf(tbl[v].dut)}, {28'd0, tbl[v].ovf});
    end

    // Independence: ch0 up, ch1 down, ch2 held, ch3 loaded with random data.
    for (int n = 0; n < 1000; n++) begin
      clr  = {2'b00, ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 3)};
      load = 4'b1000;
      en   = 4'b0011;
      dir  = 4'b0001;
      d    = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
      cycle();
      if ($urandom_range(0, 99) < 2) async_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
